// File: rtl/issue_ctrl_if.sv
// Bundles the issue_ctrl instruction handshake, register-file/ALU control outputs,
// status outputs and the retire-counter preload/state debug signals.
interface issue_ctrl_if;
  // Handshake: an instruction transfers on a rising clk edge where instr_valid && instr_ready;
  // the source holds instr stable while instr_valid is high and the transfer has not happened.
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        zero_flag;
  logic [4:0]  mem_read_addr_1;
  logic [4:0]  mem_read_addr_2;
  logic [4:0]  mem_write_addr;
  logic [3:0]  alu_ctrl;
  logic        r_or_w;
  logic        done;
  logic        illegal;
  logic        zero_latched;
  logic [15:0] retire_count;
  logic        dbg_cnt_load;
  logic [15:0] dbg_cnt_val;
  logic [2:0]  dbg_state;

  modport slave (
    input  instr_valid, instr, zero_flag, dbg_cnt_load, dbg_cnt_val,
    output instr_ready, mem_read_addr_1, mem_read_addr_2, mem_write_addr, alu_ctrl,
           r_or_w, done, illegal, zero_latched, retire_count, dbg_state
  );

  modport master (
    output instr_valid, instr, zero_flag, dbg_cnt_load, dbg_cnt_val,
    input  instr_ready, mem_read_addr_1, mem_read_addr_2, mem_write_addr, alu_ctrl,
           r_or_w, done, illegal, zero_latched, retire_count, dbg_state
  );
endinterface

// File: rtl/issue_ctrl.sv
// RV32 R-type issue controller: IDLE -> DECODE -> EXEC -> WB, illegal words go to ILL.
// Optional macro ISSUE_BACK_TO_BACK_EN lets WB accept the next instruction directly.
module issue_ctrl (
  input logic         clk,
  input logic         reset,
  issue_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_ILL    = 3'd4
  } state_e;

  localparam logic [6:0] OPC_OP = 7'b0110011;

  state_e      state_q, state_d;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [3:0]  alu_q;
  logic        zero_latched_q;
  logic [15:0] retire_count_q;

  logic        accept;
  logic        in_legal;
  logic [4:0]  in_dec;

  // Returns {legal, alu_ctrl} for a funct7/funct3 pair.
  function automatic logic [4:0] alu_decode(input logic [6:0] f7, input logic [2:0] f3);
    logic [4:0] r;
    r = 5'b0_0000;
    case ({f7, f3})
      {7'h00, 3'b000}: r = 5'b1_0010;
      {7'h20, 3'b000}: r = 5'b1_0110;
      {7'h00, 3'b111}: r = 5'b1_0000;
      {7'h00, 3'b110}: r = 5'b1_0001;
      {7'h00, 3'b100}: r = 5'b1_0011;
      {7'h00, 3'b010}: r = 5'b1_0111;
      {7'h00, 3'b001}: r = 5'b1_1000;
      {7'h00, 3'b101}: r = 5'b1_1001;
      {7'h20, 3'b101}: r = 5'b1_1010;
      {7'h00, 3'b011}: r = 5'b1_1011;
      default:         r = 5'b0_0000;
    endcase
    return r;
  endfunction

  assign in_dec   = alu_decode(bus.instr[31:25], bus.instr[14:12]);
  assign in_legal = (bus.instr[6:0] == OPC_OP) && in_dec[4];
  assign accept   = bus.instr_valid && bus.instr_ready;

  always_comb begin
    state_d             = state_q;
    bus.instr_ready     = 1'b0;
    bus.mem_read_addr_1 = 5'd0;
    bus.mem_read_addr_2 = 5'd0;
    bus.mem_write_addr  = 5'd0;
    bus.alu_ctrl        = 4'd0;
    bus.r_or_w          = 1'b0;
    bus.done            = 1'b0;
    bus.illegal         = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        if (accept) state_d = in_legal ? S_DECODE : S_ILL;
      end
      S_DECODE, S_EXEC: begin
        bus.mem_read_addr_1 = rs1_q;
        bus.mem_read_addr_2 = rs2_q;
        bus.alu_ctrl        = alu_q;
        state_d             = (state_q == S_DECODE) ? S_EXEC : S_WB;
      end
      S_WB: begin
        bus.mem_read_addr_1 = rs1_q;
        bus.mem_read_addr_2 = rs2_q;
        bus.alu_ctrl        = alu_q;
        bus.mem_write_addr  = rd_q;
        // Writes to x0 are suppressed but still retire.
        bus.r_or_w          = (rd_q != 5'd0);
        bus.done            = 1'b1;
        state_d             = S_IDLE;
`ifdef ISSUE_BACK_TO_BACK_EN
        bus.instr_ready     = 1'b1;
        if (accept) state_d = in_legal ? S_DECODE : S_ILL;
`endif
      end
      S_ILL: begin
        bus.illegal = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      rs1_q          <= 5'd0;
      rs2_q          <= 5'd0;
      rd_q           <= 5'd0;
      alu_q          <= 4'd0;
      zero_latched_q <= 1'b0;
      retire_count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rs1_q <= bus.instr[19:15];
        rs2_q <= bus.instr[24:20];
        rd_q  <= bus.instr[11:7];
        alu_q <= in_dec[3:0];
      end
      if (state_q == S_EXEC) zero_latched_q <= bus.zero_flag;
      if (bus.dbg_cnt_load)       retire_count_q <= bus.dbg_cnt_val;
      else if (state_q == S_WB)   retire_count_q <= retire_count_q + 16'd1;
    end
  end

  assign bus.zero_latched = zero_latched_q;
  assign bus.retire_count = retire_count_q;
  assign bus.dbg_state    = state_q;

endmodule
